// File: rtl/calc_pkg.sv
// Shared encodings and widths for the sequenced calculator controller.
package calc_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Keypad-side inputs and display-side outputs of the calculator controller.
interface calc_seq_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    import calc_pkg::*;

    logic                ENTER_N;
    logic                CLEAR;
    logic                ADDSUB;
    logic [WIDTH-1:0]    DATA_IN;
    logic                DATA_VALID;
    logic                ENTER_PULSE;
    logic                REJECT;
    logic [1:0]          STATE;
    logic [CNT_W-1:0]    OP_COUNT;
    logic                SELECT;
    logic [WIDTH-1:0]    ACC;
    logic [WIDTH-1:0]    RESULT;
    logic                RESULT_VALID;
    logic                OVR;
    logic                COUT;

    modport master (
        output ENTER_N, CLEAR, ADDSUB, DATA_IN, DATA_VALID,
        input  ENTER_PULSE, REJECT, STATE, OP_COUNT, SELECT, ACC, RESULT,
               RESULT_VALID, OVR, COUT
    );

    modport slave (
        input  ENTER_N, CLEAR, ADDSUB, DATA_IN, DATA_VALID,
        output ENTER_PULSE, REJECT, STATE, OP_COUNT, SELECT, ACC, RESULT,
               RESULT_VALID, OVR, COUT
    );

endinterface

// File: rtl/enter_pulse_gen.sv
// Synchronises the raw ENTER button and emits one pulse per press.
module enter_pulse_gen (
    input  logic CLOCK,
    input  logic RESET,
    input  logic ENTER_N,
    output logic ENTER_PULSE
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // Flops reset to the released level so reset release never fakes a press.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= ENTER_N;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign ENTER_PULSE = hist_q & ~sync2_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequences NUM_OPS keypad operands through an add/subtract accumulator.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OPS = 2
) (
    input  logic            CLOCK,
    input  logic            RESET,
    calc_seq_ctrl_if.slave  bus
);

    localparam int unsigned SUM_W = WIDTH + 1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovr_q, ovr_d;
    logic                cout_q, cout_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                reject_q, reject_d;

    logic                pulse;
    logic                valid;
    logic [WIDTH-1:0]    b_eff;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_op;

    enter_pulse_gen u_enter (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .ENTER_N     (bus.ENTER_N),
        .ENTER_PULSE (pulse)
    );

    assign valid   = bus.DATA_VALID;
    assign b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
    assign sum     = SUM_W'(acc_q) + SUM_W'(b_eff) + SUM_W'(op_q);
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign last_op = (cnt_inc == CNT_W'(NUM_OPS));

    // State and datapath registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            cout_q   <= 1'b0;
            result_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            cout_q   <= cout_d;
            result_q <= result_d;
            reject_q <= reject_d;
        end
    end

    // Next-state logic; CLEAR overrides any pulse.
    always_comb begin
        state_d = state_q;
        if (bus.CLEAR) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (pulse && valid) state_d = ST_LOAD;
                ST_LOAD: if (pulse && valid) state_d = ST_EXEC;
                ST_EXEC: state_d = last_op ? ST_DONE : ST_LOAD;
                ST_DONE: if (pulse) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values and reject pulse.
    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        cout_d   = cout_q;
        result_d = result_q;
        reject_d = 1'b0;
        if (bus.CLEAR) begin
            acc_d    = '0;
            b_d      = '0;
            cnt_d    = '0;
            ovr_d    = 1'b0;
            cout_d   = 1'b0;
            result_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pulse && valid) begin
                        acc_d  = bus.DATA_IN;
                        cnt_d  = CNT_W'(1);
                        ovr_d  = 1'b0;
                        cout_d = 1'b0;
                    end else if (pulse) begin
                        reject_d = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (pulse && valid) begin
                        b_d  = bus.DATA_IN;
                        op_d = bus.ADDSUB;
                    end else if (pulse) begin
                        reject_d = 1'b1;
                    end
                end
                ST_EXEC: begin
                    acc_d  = sum[WIDTH-1:0];
                    cout_d = sum[WIDTH];
                    ovr_d  = ovr_q | ((acc_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                                      (sum[WIDTH-1] != acc_q[WIDTH-1]));
                    cnt_d  = cnt_inc;
                    if (last_op) result_d = sum[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.ENTER_PULSE  = pulse;
    assign bus.REJECT       = reject_q;
    assign bus.STATE        = state_q;
    assign bus.OP_COUNT     = cnt_q;
    assign bus.SELECT       = (state_q == ST_DONE);
    assign bus.RESULT_VALID = (state_q == ST_DONE);
    assign bus.ACC          = acc_q;
    assign bus.RESULT       = result_q;
    assign bus.OVR          = ovr_q;
    assign bus.COUT         = cout_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl with WIDTH=8, NUM_OPS=3.
module tb_calc_seq_ctrl;
    import calc_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned N = 3;

    logic CLOCK = 1'b0;
    logic RESET;

    always #5 CLOCK = ~CLOCK;

    calc_seq_ctrl_if #(.WIDTH(W)) bus ();

    calc_seq_ctrl #(.WIDTH(W), .NUM_OPS(N)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] acc;
        logic [3:0] cnt;
        logic       ovr;
        logic       cout;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulse_cnt = 0;

    logic [7:0] m_acc;
    int         m_cnt;
    logic       m_ovr;
    logic       m_cout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLOCK) if (bus.ENTER_PULSE === 1'b1) pulse_cnt++;

    // Pops an expectation whenever the DUT lands in LOAD or DONE.
    logic [1:0] prev_st = 2'b00;
    always @(negedge CLOCK) begin
        exp_t e;
        if (RESET === 1'b0 && bus.STATE != prev_st &&
            (bus.STATE == ST_LOAD || bus.STATE == ST_DONE)) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_acc",   32'(bus.ACC),      32'(e.acc));
                check("sb_cnt",   32'(bus.OP_COUNT), 32'(e.cnt));
                check("sb_ovr",   32'(bus.OVR),      32'(e.ovr));
                check("sb_cout",  32'(bus.COUT),     32'(e.cout));
                check("sb_state", 32'(bus.STATE),    e.done ? 32'(ST_DONE) : 32'(ST_LOAD));
                check("sb_sel",   32'(bus.SELECT),   32'(e.done));
                if (e.done) begin
                    check("sb_result", 32'(bus.RESULT),       32'(e.acc));
                    check("sb_rvalid", 32'(bus.RESULT_VALID), 32'd1);
                end
            end
        end
        prev_st = bus.STATE;
    end

    // Independent reference: signed range check for overflow, unsigned compare for carry.
    task automatic model_commit(input logic [7:0] d, input logic as);
        int a_s, b_s, t;
        exp_t e;
        if (m_cnt == 0) begin
            m_acc = d; m_cnt = 1; m_ovr = 1'b0; m_cout = 1'b0;
        end else begin
            a_s = $signed(m_acc);
            b_s = $signed(d);
            if (as) begin
                m_cout = (m_acc >= d);
                t = a_s - b_s;
            end else begin
                m_cout = ((int'(m_acc) + int'(d)) > 255);
                t = a_s + b_s;
            end
            if (t > 127 || t < -128) m_ovr = 1'b1;
            m_acc = 8'(t);
            m_cnt++;
        end
        e.acc = m_acc; e.cnt = 4'(m_cnt); e.ovr = m_ovr; e.cout = m_cout;
        e.done = (m_cnt == int'(N));
        sb.push_back(e);
    endtask

    task automatic press(input logic [7:0] d, input logic v, input logic as,
                         input int hold, input logic commit, input logic chk_t);
        logic pa, pb;
        @(negedge CLOCK);
        bus.DATA_IN = d; bus.DATA_VALID = v; bus.ADDSUB = as; bus.ENTER_N = 1'b0;
        if (commit) model_commit(d, as);
        @(negedge CLOCK); pa = bus.ENTER_PULSE;
        @(negedge CLOCK); pb = bus.ENTER_PULSE;
        if (chk_t) begin
            check("pulse_early", 32'(pa), 32'd0);
            check("pulse_k1",    32'(pb), 32'd1);
        end
        repeat (hold > 2 ? hold - 2 : 0) @(negedge CLOCK);
        bus.ENTER_N = 1'b1;
        repeat (6) @(negedge CLOCK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},  32'(bus.STATE),        32'd0);
        check({tag, "_cnt"},    32'(bus.OP_COUNT),     32'd0);
        check({tag, "_acc"},    32'(bus.ACC),          32'd0);
        check({tag, "_result"}, 32'(bus.RESULT),       32'd0);
        check({tag, "_rvalid"}, 32'(bus.RESULT_VALID), 32'd0);
        check({tag, "_sel"},    32'(bus.SELECT),       32'd0);
        check({tag, "_ovr"},    32'(bus.OVR),          32'd0);
        check({tag, "_cout"},   32'(bus.COUT),         32'd0);
        check({tag, "_reject"}, 32'(bus.REJECT),       32'd0);
        check({tag, "_pulse"},  32'(bus.ENTER_PULSE),  32'd0);
    endtask

    initial begin
        int p0;
        RESET = 1'b1;
        bus.ENTER_N = 1'b1; bus.CLEAR = 1'b0; bus.ADDSUB = 1'b0;
        bus.DATA_IN = '0; bus.DATA_VALID = 1'b0;
        m_cnt = 0; m_acc = '0; m_ovr = 1'b0; m_cout = 1'b0;

        // Reset and idle
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (10) @(negedge CLOCK);
        check_all_zero("rst");
        check("rst_pulses", 32'(pulse_cnt), 32'd0);

        // 5 + 3 - 2
        press(8'd5, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        press(8'd3, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        press(8'd2, 1'b1, 1'b1, 2, 1'b1, 1'b1);
        check("t2_result", 32'(bus.RESULT), 32'd6);
        check("t2_cout",   32'(bus.COUT),   32'd1);

        // Press in DONE returns to IDLE, RESULT held
        press(8'd0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        m_cnt = 0;
        check("done_state",  32'(bus.STATE),        32'(ST_IDLE));
        check("done_rvalid", 32'(bus.RESULT_VALID), 32'd0);
        check("done_result", 32'(bus.RESULT),       32'd6);

        // 100 + 100 - 100, sticky overflow
        press(8'd100, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        press(8'd100, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        check("t3_mid_acc", 32'(bus.ACC), 32'h0C8);
        check("t3_mid_ovr", 32'(bus.OVR), 32'd1);
        press(8'd100, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        check("t3_result", 32'(bus.RESULT), 32'h064);
        check("t3_ovr",    32'(bus.OVR),    32'd1);
        press(8'd0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        m_cnt = 0;

        // Reject in LOAD
        press(8'd7, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        @(negedge CLOCK); bus.DATA_VALID = 1'b0; bus.ENTER_N = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK); bus.ENTER_N = 1'b1;
        @(negedge CLOCK);
        check("rej_pulse", 32'(bus.REJECT),   32'd1);
        check("rej_state", 32'(bus.STATE),    32'(ST_LOAD));
        check("rej_cnt",   32'(bus.OP_COUNT), 32'd1);
        @(negedge CLOCK);
        check("rej_one_cycle", 32'(bus.REJECT), 32'd0);
        repeat (4) @(negedge CLOCK);

        // Long hold gives one pulse
        p0 = pulse_cnt;
        press(8'd0, 1'b0, 1'b0, 50, 1'b0, 1'b0);
        check("hold_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("hold_state",  32'(bus.STATE),      32'(ST_LOAD));
        check("hold_cnt",    32'(bus.OP_COUNT),   32'd1);

        // CLEAR during EXEC
        @(negedge CLOCK); bus.DATA_IN = 8'd4; bus.DATA_VALID = 1'b1; bus.ADDSUB = 1'b0; bus.ENTER_N = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK); bus.ENTER_N = 1'b1;
        @(negedge CLOCK);
        check("clr_in_exec", 32'(bus.STATE), 32'(ST_EXEC));
        bus.CLEAR = 1'b1;
        @(negedge CLOCK);
        bus.CLEAR = 1'b0;
        m_cnt = 0;
        check("clr_state",  32'(bus.STATE),    32'(ST_IDLE));
        check("clr_acc",    32'(bus.ACC),      32'd0);
        check("clr_cnt",    32'(bus.OP_COUNT), 32'd0);
        check("clr_reject", 32'(bus.REJECT),   32'd0);
        repeat (4) @(negedge CLOCK);

        // CLEAR coincident with an invalid-data pulse in LOAD
        press(8'd11, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        @(negedge CLOCK); bus.DATA_VALID = 1'b0; bus.ENTER_N = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK); bus.ENTER_N = 1'b1; bus.CLEAR = 1'b1;
        @(negedge CLOCK); bus.CLEAR = 1'b0;
        m_cnt = 0;
        check("clrp_state",  32'(bus.STATE),  32'(ST_IDLE));
        check("clrp_acc",    32'(bus.ACC),    32'd0);
        check("clrp_reject", 32'(bus.REJECT), 32'd0);
        @(negedge CLOCK);
        check("clrp_reject2", 32'(bus.REJECT), 32'd0);
        repeat (4) @(negedge CLOCK);

        // RESET mid-LOAD
        press(8'd9, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        check("pre_rst_acc", 32'(bus.ACC), 32'd9);
        @(negedge CLOCK); RESET = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        m_cnt = 0;
        repeat (4) @(negedge CLOCK);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Parametrised successor to the calculator control unit.
- Sequences entry of NUM_OPS signed operands from the keypad input unit, applies add or subtract per operand into a WIDTH-bit accumulator, then presents the result.
- Adds behaviour the 4-state controller lacks: operand count is a parameter, add/subtract is chosen per operand, overflow is sticky, invalid entries are rejected, a synchronous CLEAR is provided, and the block returns to idle after the result so a new calculation can start.
- Sits between the keypad input unit (DATA_IN/DATA_VALID) and the output mux/display unit (SELECT/RESULT).

Parameters:
- WIDTH, 8, operand/accumulator width in bits (two's complement), range 4..16.
- NUM_OPS, 2, number of operands per calculation, range 2..15.

Ports:
- CLOCK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- ENTER_N  input  1  raw active-low ENTER pushbutton, asynchronous to CLOCK.
- CLEAR  input  1  synchronous abort to idle.
- ADDSUB  input  1  0 = add, 1 = subtract. Sampled when each operand after the first is committed.
- DATA_IN  input  WIDTH  two's-complement operand from the keypad unit.
- DATA_VALID  input  1  DATA_IN holds a legal value.
- ENTER_PULSE  output  1  one-cycle pulse per ENTER press.
- REJECT  output  1  one-cycle pulse when ENTER arrives while DATA_VALID=0 in IDLE or LOAD.
- STATE  output  2  current state encoding.
- OP_COUNT  output  4  operands committed so far.
- SELECT  output  1  0 = display DATA_IN, 1 = display RESULT.
- ACC  output  WIDTH  running accumulator.
- RESULT  output  WIDTH  registered final result.
- RESULT_VALID  output  1  high while in DONE.
- OVR  output  1  sticky signed overflow for the current calculation.
- COUT  output  1  carry-out of the last EXEC.

Behaviour:
Reset:
- RESET=1 forces IDLE (00) and clears all outputs and registers to 0.
- ENTER synchroniser flops reset to 1 (button released), so no pulse occurs on reset release.

Enter pulse generation:
- Two-flop synchroniser followed by a history flop; ENTER_PULSE = hist & ~sync.
- ENTER_N sampled low at edge k: ENTER_PULSE is high from edge k+1 to edge k+2, and the FSM acts at edge k+2.
- Exactly one pulse per press, regardless of hold length.

States:
- IDLE (00): SELECT=0.
  - pulse & DATA_VALID: ACC<=DATA_IN, OP_COUNT<=1, OVR<=0, COUT<=0, go to LOAD.
  - pulse & !DATA_VALID: REJECT, stay in IDLE.
- LOAD (01): SELECT=0.
  - pulse & DATA_VALID: B<=DATA_IN, op<=ADDSUB, go to EXEC.
  - pulse & !DATA_VALID: REJECT, stay in LOAD.
- EXEC (10): single cycle.
  - ACC <= ACC + B (add) or ACC + ~B + 1 (subtract), truncated to WIDTH bits (wrap-around).
  - COUT <= bit WIDTH of that sum.
  - OVR <= OVR | (sign(ACC) == sign(effective B) && sign(new ACC) != sign(ACC)).
  - OP_COUNT++.
  - If the incremented OP_COUNT == NUM_OPS: RESULT<=new ACC, go to DONE. Otherwise go to LOAD.
  - A pulse arriving in EXEC is dropped, with no REJECT.
- DONE (11): SELECT=1, RESULT_VALID=1.
  - pulse: go to IDLE. RESULT_VALID drops; RESULT, OVR and COUT hold until the next first-operand commit.

CLEAR:
- Highest priority below RESET, in any state.
- Next state is IDLE; ACC, B, OP_COUNT, OVR, COUT, RESULT and RESULT_VALID are cleared.
- A simultaneous pulse is ignored, with no REJECT.

Timing and reset:
- All outputs are registered except ENTER_PULSE, SELECT and RESULT_VALID, which decode from registers.
- RESET mid-operation aborts immediately with no partial RESULT.

Decomposition:
- Package calc_pkg:
  - State encodings ST_IDLE=2'b00, ST_LOAD=2'b01, ST_EXEC=2'b10, ST_DONE=2'b11.
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - OP_COUNT width constant = 4.
- One sub-module, enter_pulse_gen: synchroniser plus falling-edge detector, CLOCK/RESET/ENTER_N in, ENTER_PULSE out.

Test Plan:
All scenarios use WIDTH=8, NUM_OPS=3.
1. Reset sequence: assert RESET with ENTER_N=1, release, run 10 cycles. Required: all outputs 0, STATE=00, no ENTER_PULSE.
2. Enter 5, then 3 with ADDSUB=0, then 2 with ADDSUB=1, DATA_VALID=1. Required: ENTER_PULSE two cycles after each press; ACC 5→8→6; COUT=1 after the subtract; RESULT=6, RESULT_VALID=1, SELECT=1, OVR=0, STATE=11.
3. 100 + 100 - 100. Required: ACC=0xC8 with OVR=1 after the second op; final RESULT=100 (0x64) with OVR still 1 (sticky).
4. Sequence of faults:
   - Press ENTER in LOAD with DATA_VALID=0. Required: REJECT for one cycle, STATE stays 01, OP_COUNT unchanged.
   - Hold ENTER_N low for 50 cycles. Required: exactly one pulse.
5. Assert CLEAR in the EXEC cycle, coincident with a pulse. Required: next STATE=00, ACC=0, OP_COUNT=0, no REJECT.
6. Press ENTER in DONE. Required: STATE=00, RESULT_VALID=0, RESULT holds 6. Then assert RESET mid-LOAD. Required: immediate return to all-zero outputs.
